// File: rtl/tdp_ram_bytewise_cfg_pkg.sv
// Shared constants for the configurable byte-write true-dual-port RAM.
//   RDW_*  : per-port read-during-write mode encodings (MODE_A / MODE_B parameters)
//   state_e: initialisation FSM states (ST_CLEAR sweep, ST_READY terminal)
package tdp_ram_bytewise_cfg_pkg;

  localparam int unsigned RDW_READ_FIRST  = 0;
  localparam int unsigned RDW_WRITE_FIRST = 1;
  localparam int unsigned RDW_NO_CHANGE   = 2;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_e;

endpackage

// File: rtl/tdp_ram_bytewise_cfg_out_pipe.sv
// tdp_ram_out_pipe: one extra register stage for a read port's dout/dvalid.
// Ports:
//   clk, nrst          clock, asynchronous active-low reset
//   i_data / i_valid   first-stage read data and its fresh-data pulse
//   o_data / o_valid   same, delayed by one cycle
module tdp_ram_out_pipe
  import tdp_ram_bytewise_cfg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid
);

  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;

  // The first stage already holds its data when idle, so a plain copy keeps
  // the hold behaviour intact.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_data  <= i_data;
      r_valid <= i_valid;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/tdp_ram_bytewise_cfg.sv
// Single-clock true-dual-port RAM with per-byte write enables, per-port read-during-write
// mode, deterministic same-address collision handling, optional output register and an
// optional post-reset clear sweep.
// Ports:
//   clk, nrst            clock, asynchronous active-low reset (array contents not reset)
//   init_done            1 once the array is usable; requests are ignored while 0
//   enaA/enaB            port request, weA/weB byte write enables (all zero = read)
//   addrA/addrB          word address, dinA/dinB write data
//   doutA/doutB          read data, dvalidA/dvalidB one-cycle pulse with fresh dout
module tdp_ram_bytewise_cfg
  import tdp_ram_bytewise_cfg_pkg::*;
#(
  parameter int unsigned           NUM_COL      = 4,
  parameter int unsigned           COL_WIDTH    = 8,
  parameter int unsigned           ADDR_WIDTH   = 11,
  parameter int unsigned           DATA_WIDTH   = NUM_COL * COL_WIDTH,
  parameter int unsigned           MODE_A       = RDW_READ_FIRST,
  parameter int unsigned           MODE_B       = RDW_READ_FIRST,
  parameter bit                    OUT_REG      = 1'b0,
  parameter bit                    CLEAR_EN     = 1'b0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VAL    = '0,
  parameter string                 INITIAL_DATA = "datamem.coe"
) (
  input  logic                  clk,
  input  logic                  nrst,
  output logic                  init_done,
  input  logic                  enaA,
  input  logic [NUM_COL-1:0]    weA,
  input  logic [ADDR_WIDTH-1:0] addrA,
  input  logic [DATA_WIDTH-1:0] dinA,
  output logic [DATA_WIDTH-1:0] doutA,
  output logic                  dvalidA,
  input  logic                  enaB,
  input  logic [NUM_COL-1:0]    weB,
  input  logic [ADDR_WIDTH-1:0] addrB,
  input  logic [DATA_WIDTH-1:0] dinB,
  output logic [DATA_WIDTH-1:0] doutB,
  output logic                  dvalidB
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  // Replace the lanes selected by be with the matching lanes of data.
  function automatic logic [DATA_WIDTH-1:0] merge_lanes(input logic [DATA_WIDTH-1:0] base,
                                                        input logic [DATA_WIDTH-1:0] data,
                                                        input logic [NUM_COL-1:0]    be);
    logic [DATA_WIDTH-1:0] res;
    res = base;
    for (int i = 0; i < NUM_COL; i++) begin
      if (be[i]) res[i*COL_WIDTH +: COL_WIDTH] = data[i*COL_WIDTH +: COL_WIDTH];
    end
    return res;
  endfunction

  // -------------------------------------------------------------------------
  // Initialisation FSM
  // -------------------------------------------------------------------------
  state_e                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_addr, w_clr_addr_nxt;
  logic                  w_clearing;
  logic                  w_ready;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      if (CLEAR_EN) r_state <= ST_CLEAR;
      else          r_state <= ST_READY;
      r_clr_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_addr <= w_clr_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_clr_addr_nxt = r_clr_addr;
    w_clearing     = 1'b0;
    w_ready        = 1'b0;
    unique case (r_state)
      ST_CLEAR: begin
        w_clearing     = 1'b1;
        w_clr_addr_nxt = r_clr_addr + ADDR_WIDTH'(1);
        if (&r_clr_addr) w_state_nxt = ST_READY;
      end
      ST_READY: w_ready = 1'b1;
    endcase
  end

  assign init_done = w_ready;

  // -------------------------------------------------------------------------
  // Array
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic w_actA, w_actB;
  assign w_actA = enaA & w_ready;
  assign w_actB = enaB & w_ready;

  // Port B lanes are assigned before port A lanes, so on a same-address,
  // same-lane collision the later non-blocking assignment (port A) wins.
  always_ff @(posedge clk) begin
    if (w_clearing) begin
      r_mem[r_clr_addr] <= CLEAR_VAL;
    end else begin
      for (int i = 0; i < NUM_COL; i++) begin
        if (w_actB && weB[i]) r_mem[addrB][i*COL_WIDTH +: COL_WIDTH] <= dinB[i*COL_WIDTH +: COL_WIDTH];
        if (w_actA && weA[i]) r_mem[addrA][i*COL_WIDTH +: COL_WIDTH] <= dinA[i*COL_WIDTH +: COL_WIDTH];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read path, first stage
  // -------------------------------------------------------------------------
  logic                  w_same_addr;
  logic [DATA_WIDTH-1:0] w_oldA, w_oldB, w_newA, w_newB, w_rdA, w_rdB;
  logic                  w_updA, w_updB;

  assign w_same_addr = (addrA == addrB);
  assign w_oldA      = r_mem[addrA];
  assign w_oldB      = r_mem[addrB];

  // Word as it will stand after this edge, including the other port's lanes
  // when both write the same address (A-priority per lane).
  assign w_newA = merge_lanes(merge_lanes(w_oldA, dinB, (w_actB && w_same_addr) ? weB : '0),
                              dinA, weA);
  assign w_newB = merge_lanes(merge_lanes(w_oldB, dinB, weB),
                              dinA, (w_actA && w_same_addr) ? weA : '0);

  // A read (we == 0) always returns the pre-edge word, which also gives the
  // cross-port read-first behaviour when the other port writes the same word.
  assign w_updA = (weA == '0) || (MODE_A != RDW_NO_CHANGE);
  assign w_updB = (weB == '0) || (MODE_B != RDW_NO_CHANGE);
  assign w_rdA  = ((weA != '0) && (MODE_A == RDW_WRITE_FIRST)) ? w_newA : w_oldA;
  assign w_rdB  = ((weB != '0) && (MODE_B == RDW_WRITE_FIRST)) ? w_newB : w_oldB;

  logic [DATA_WIDTH-1:0] r_doA, r_doB;
  logic                  r_dvA, r_dvB;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_doA <= '0;
      r_dvA <= 1'b0;
      r_doB <= '0;
      r_dvB <= 1'b0;
    end else begin
      r_dvA <= 1'b0;
      r_dvB <= 1'b0;
      if (w_actA && w_updA) begin
        r_doA <= w_rdA;
        r_dvA <= 1'b1;
      end
      if (w_actB && w_updB) begin
        r_doB <= w_rdB;
        r_dvB <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Optional output register
  // -------------------------------------------------------------------------
  if (OUT_REG) begin : g_out_reg
    tdp_ram_out_pipe #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_pipe_a (
      .clk     (clk),
      .nrst    (nrst),
      .i_data  (r_doA),
      .i_valid (r_dvA),
      .o_data  (doutA),
      .o_valid (dvalidA)
    );
    tdp_ram_out_pipe #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_pipe_b (
      .clk     (clk),
      .nrst    (nrst),
      .i_data  (r_doB),
      .i_valid (r_dvB),
      .o_data  (doutB),
      .o_valid (dvalidB)
    );
  end else begin : g_no_out_reg
    assign doutA   = r_doA;
    assign dvalidA = r_dvA;
    assign doutB   = r_doB;
    assign dvalidB = r_dvB;
  end

endmodule

// File: tb/tb_tdp_ram_bytewise_cfg.sv
module tb_tdp_ram_bytewise_cfg;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] CLR   = 32'h0BAD_F00D;

  logic        clk  = 1'b0;
  logic        nrst = 1'b0;
  logic        enaA = 1'b0, enaB = 1'b0;
  logic [3:0]  weA  = '0, weB = '0, addrA = '0, addrB = '0;
  logic [31:0] dinA = '0, dinB = '0;

  // dut0: A READ_FIRST, B WRITE_FIRST, latency 1. dut1: both NO_CHANGE, latency 2.
  logic        done0, done1, dvA0, dvB0, dvA1, dvB1;
  logic [31:0] doA0, doB0, doA1, doB1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tdp_ram_bytewise_cfg #(
    .NUM_COL (4), .COL_WIDTH (8), .ADDR_WIDTH (4), .MODE_A (0), .MODE_B (1),
    .OUT_REG (1'b0), .CLEAR_EN (1'b1), .CLEAR_VAL (CLR)
  ) dut0 (
    .clk (clk), .nrst (nrst), .init_done (done0),
    .enaA (enaA), .weA (weA), .addrA (addrA), .dinA (dinA), .doutA (doA0), .dvalidA (dvA0),
    .enaB (enaB), .weB (weB), .addrB (addrB), .dinB (dinB), .doutB (doB0), .dvalidB (dvB0)
  );

  tdp_ram_bytewise_cfg #(
    .NUM_COL (4), .COL_WIDTH (8), .ADDR_WIDTH (4), .MODE_A (2), .MODE_B (2),
    .OUT_REG (1'b1), .CLEAR_EN (1'b1), .CLEAR_VAL (CLR)
  ) dut1 (
    .clk (clk), .nrst (nrst), .init_done (done1),
    .enaA (enaA), .weA (weA), .addrA (addrA), .dinA (dinA), .doutA (doA1), .dvalidA (dvA1),
    .enaB (enaB), .weB (weB), .addrB (addrB), .dinB (dinB), .doutB (doB1), .dvalidB (dvB1)
  );

  // ---------------------------------------------------------------------------
  // Reference model: memory image plus the visible outputs of each DUT.
  // ---------------------------------------------------------------------------
  logic [31:0] mm [DEPTH];
  bit          m_ready;
  logic [31:0] e0_doA, e0_doB, s1_doA, s1_doB, e1_doA, e1_doB;
  logic        e0_dvA, e0_dvB, s1_dvA, s1_dvB, e1_dvA, e1_dvB;

  function automatic logic [31:0] lanes(input logic [31:0] base, input logic [31:0] data,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = base;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = data[8*i +: 8];
    return r;
  endfunction

  // mode 0 read-first, 1 write-first, 2 no-change; prev is the held output.
  task automatic port_model(input int mode, input bit act, input logic [3:0] we,
                            input logic [31:0] old, input logic [31:0] after,
                            input logic [31:0] prev, output logic [31:0] dout, output logic dv);
    dout = prev;
    dv   = 1'b0;
    if (act) begin
      if (we == 4'b0 || mode == 0) begin dout = old;   dv = 1'b1; end
      else if (mode == 1)          begin dout = after; dv = 1'b1; end
    end
  endtask

  task automatic model_reset();
    m_ready = 0;
    {e0_doA, e0_doB, s1_doA, s1_doB, e1_doA, e1_doB} = '0;
    {e0_dvA, e0_dvB, s1_dvA, s1_dvB, e1_dvA, e1_dvB} = '0;
  endtask

  // Drive one cycle of requests, advance the model, sample #1 after the edge.
  task automatic step(input bit ea, input logic [3:0] wa, input logic [3:0] aa,
                      input logic [31:0] da, input bit eb, input logic [3:0] wb,
                      input logic [3:0] ab, input logic [31:0] db);
    logic [31:0] oldA, oldB;
    bit actA, actB;
    enaA = ea; weA = wa; addrA = aa; dinA = da;
    enaB = eb; weB = wb; addrB = ab; dinB = db;
    actA = ea && m_ready;
    actB = eb && m_ready;
    oldA = mm[aa];
    oldB = mm[ab];
    if (actB) mm[ab] = lanes(mm[ab], db, wb);
    if (actA) mm[aa] = lanes(mm[aa], da, wa); // applied last: A wins shared lanes
    e1_doA = s1_doA; e1_dvA = s1_dvA;
    e1_doB = s1_doB; e1_dvB = s1_dvB;
    port_model(0, actA, wa, oldA, mm[aa], e0_doA, e0_doA, e0_dvA);
    port_model(1, actB, wb, oldB, mm[ab], e0_doB, e0_doB, e0_dvB);
    port_model(2, actA, wa, oldA, mm[aa], s1_doA, s1_doA, s1_dvA);
    port_model(2, actB, wb, oldB, mm[ab], s1_doB, s1_doB, s1_dvB);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 4'h0, 4'h0, 32'h0, 0, 4'h0, 4'h0, 32'h0);
  endtask

  task automatic assert_reset();
    nrst = 1'b0;
    enaA = 1'b0;
    enaB = 1'b0;
    model_reset();
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    assert_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({done0, done1} !== 2'b00) begin
      n_fail++; $display("FAIL reset_init_done got %b%b want 00", done0, done1);
    end
    n_tests++;
    if ({dvA0, dvB0, dvA1, dvB1} !== 4'b0) begin
      n_fail++; $display("FAIL reset_dvalid got %b%b%b%b want 0000", dvA0, dvB0, dvA1, dvB1);
    end
    n_tests++;
    if ({doA0, doB0, doA1, doB1} !== 128'b0) begin
      n_fail++; $display("FAIL reset_dout got %h %h %h %h want 0", doA0, doB0, doA1, doB1);
    end
  endtask

  // Release reset and run the 16-cycle sweep with random (ignored) requests.
  task automatic test_sweep(input string tag);
    @(negedge clk);
    nrst = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step($urandom_range(0, 1) == 1, 4'($urandom), 4'($urandom), $urandom,
           $urandom_range(0, 1) == 1, 4'($urandom), 4'($urandom), $urandom);
      n_tests++;
      if (done0 !== (k >= 16) || done1 !== (k >= 16)) begin
        n_fail++;
        $display("FAIL %s_init_done cycle %0d got %b%b want %b", tag, k, done0, done1, k >= 16);
      end
      n_tests++;
      if ({dvA0, dvB0, dvA1, dvB1} !== 4'b0) begin
        n_fail++;
        $display("FAIL %s_dvalid_during_sweep cycle %0d got %b%b%b%b want 0000",
                 tag, k, dvA0, dvB0, dvA1, dvB1);
      end
    end
    m_ready = 1;
    for (int a = 0; a < DEPTH; a++) mm[a] = CLR;
  endtask

  task automatic test_clear_readback();
    for (int a = 0; a < DEPTH + 1; a++) begin
      if (a < DEPTH) step(1, 4'h0, 4'(a), $urandom, 1, 4'h0, 4'(DEPTH - 1 - a), $urandom);
      else           idle();
      if (a < DEPTH) begin
        n_tests++;
        if (doA0 !== CLR || doB0 !== CLR || dvA0 !== 1'b1 || dvB0 !== 1'b1) begin
          n_fail++;
          $display("FAIL clear_readback addr %0d got %h/%b %h/%b want %h/1", a, doA0, dvA0,
                   doB0, dvB0, CLR);
        end
      end
      if (a > 0) begin
        n_tests++;
        if (doA1 !== CLR || doB1 !== CLR || dvA1 !== 1'b1 || dvB1 !== 1'b1) begin
          n_fail++;
          $display("FAIL clear_readback_reg addr %0d got %h %h want %h", a - 1, doA1, doB1, CLR);
        end
      end
    end
  endtask

  task automatic test_mid_sweep_reset();
    step(1, 4'hF, 4'd0, 32'h1234_5678, 1, 4'hF, 4'd15, 32'h8765_4321);
    idle();
    assert_reset();
    @(negedge clk);
    nrst = 1'b1;
    repeat (7) idle(); // sweep now at clr_addr 7
    assert_reset();
    n_tests++;
    if ({done0, done1} !== 2'b00 || {doA0, doA1} !== 64'b0) begin
      n_fail++;
      $display("FAIL midsweep_reset got done %b%b dout %h %h want 00 / 0", done0, done1, doA0, doA1);
    end
    test_sweep("resweep");
    step(1, 4'h0, 4'd0, 32'h0, 1, 4'h0, 4'd15, 32'h0);
    n_tests++;
    if (doA0 !== CLR || doB0 !== CLR) begin
      n_fail++;
      $display("FAIL midsweep_cleared got %h %h want %h", doA0, doB0, CLR);
    end
    idle();
  endtask

  task automatic test_rdw();
    step(1, 4'hF, 4'd5, 32'h1122_3344, 0, 4'h0, 4'h0, 32'h0);
    idle();
    step(1, 4'b0011, 4'd5, 32'hAAAA_BBBB, 0, 4'h0, 4'h0, 32'h0);
    n_tests++;
    if (doA0 !== 32'h1122_3344 || dvA0 !== 1'b1) begin
      n_fail++; $display("FAIL rdw_read_first got %h/%b want 11223344/1", doA0, dvA0);
    end
    idle();
    n_tests++;
    if (dvA1 !== 1'b0 || doA1 !== e1_doA) begin
      n_fail++; $display("FAIL rdw_no_change got %h/%b want %h/0", doA1, dvA1, e1_doA);
    end
    step(0, 4'h0, 4'h0, 32'h0, 1, 4'hF, 4'd5, 32'h1122_3344);
    idle();
    step(0, 4'h0, 4'h0, 32'h0, 1, 4'b0011, 4'd5, 32'hAAAA_BBBB);
    n_tests++;
    if (doB0 !== 32'h1122_BBBB || dvB0 !== 1'b1) begin
      n_fail++; $display("FAIL rdw_write_first got %h/%b want 1122bbbb/1", doB0, dvB0);
    end
    step(1, 4'h0, 4'd5, 32'h0, 0, 4'h0, 4'h0, 32'h0);
    n_tests++;
    if (doA0 !== 32'h1122_BBBB) begin
      n_fail++; $display("FAIL rdw_final_mem got %h want 1122bbbb", doA0);
    end
    idle();
    n_tests++;
    if (doA1 !== 32'h1122_BBBB || dvA1 !== 1'b1) begin
      n_fail++; $display("FAIL rdw_no_change_read got %h/%b want 1122bbbb/1", doA1, dvA1);
    end
  endtask

  task automatic test_collision_ww();
    step(1, 4'hF, 4'd9, 32'h0, 0, 4'h0, 4'h0, 32'h0);
    step(1, 4'b0011, 4'd9, 32'hAAAA_AAAA, 1, 4'b0110, 4'd9, 32'hBBBB_BBBB);
    step(1, 4'h0, 4'd9, 32'h0, 0, 4'h0, 4'h0, 32'h0);
    n_tests++;
    if (doA0 !== 32'h00BB_AAAA) begin
      n_fail++; $display("FAIL collision_ww got %h want 00bbaaaa", doA0);
    end
    idle();
  endtask

  task automatic test_collision_rw();
    step(1, 4'hF, 4'd3, 32'h0102_0304, 0, 4'h0, 4'h0, 32'h0);
    step(1, 4'hF, 4'd3, 32'hDEAD_BEEF, 1, 4'h0, 4'd3, 32'h0);
    n_tests++;
    if (doB0 !== 32'h0102_0304 || dvB0 !== 1'b1) begin
      n_fail++; $display("FAIL collision_rw_old got %h/%b want 01020304/1", doB0, dvB0);
    end
    step(0, 4'h0, 4'h0, 32'h0, 1, 4'h0, 4'd3, 32'h0);
    n_tests++;
    if (doB0 !== 32'hDEAD_BEEF || doB1 !== 32'h0102_0304) begin
      n_fail++; $display("FAIL collision_rw_new got %h %h want deadbeef 01020304", doB0, doB1);
    end
    idle();
    n_tests++;
    if (doB1 !== 32'hDEAD_BEEF || dvB1 !== 1'b1) begin
      n_fail++; $display("FAIL collision_rw_reg got %h/%b want deadbeef/1", doB1, dvB1);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [4];
    for (int k = 0; k < 4; k++) begin
      w[k] = $urandom;
      step(1, 4'hF, 4'(k), w[k], 0, 4'h0, 4'h0, 32'h0);
    end
    idle();
    idle();
    for (int t = 0; t < 6; t++) begin
      if (t < 4) step(1, 4'h0, 4'(t), 32'h0, 0, 4'h0, 4'h0, 32'h0);
      else       idle();
      n_tests++;
      if (dvA1 !== (t >= 1 && t <= 4) || (t >= 1 && t <= 4 && doA1 !== w[(t + 3) % 4])) begin
        n_fail++;
        $display("FAIL back_to_back t=%0d got %h/%b want %h/%b", t, doA1, dvA1,
                 w[(t + 3) % 4], t >= 1 && t <= 4);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 9) < 8, $urandom_range(0, 1) ? 4'h0 : 4'($urandom),
           $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom), $urandom,
           $urandom_range(0, 9) < 8, $urandom_range(0, 1) ? 4'h0 : 4'($urandom),
           $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom), $urandom);
      n_tests++;
      if (doA0 !== e0_doA || dvA0 !== e0_dvA || doB0 !== e0_doB || dvB0 !== e0_dvB) begin
        n_fail++;
        $display("FAIL random_dut0 n=%0d got %h/%b %h/%b want %h/%b %h/%b", n, doA0, dvA0,
                 doB0, dvB0, e0_doA, e0_dvA, e0_doB, e0_dvB);
      end
      n_tests++;
      if (doA1 !== e1_doA || dvA1 !== e1_dvA || doB1 !== e1_doB || dvB1 !== e1_dvB) begin
        n_fail++;
        $display("FAIL random_dut1 n=%0d got %h/%b %h/%b want %h/%b %h/%b", n, doA1, dvA1,
                 doB1, dvB1, e1_doA, e1_dvA, e1_doB, e1_dvB);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) mm[a] = '0;
    test_reset();
    test_sweep("sweep");
    test_clear_readback();
    test_mid_sweep_reset();
    test_rdw();
    test_collision_ww();
    test_collision_rw();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
